// File: rtl/cu_seq_pkg.sv
// Shared opcodes, FSM state and helpers for the compute-unit issue sequencer.
package cu_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_NOT  = 4'hE;
  localparam logic [3:0] OP_XOR  = 4'hF;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

  // One result-tracking stage: was the presented word real, and its opcode.
  typedef struct packed {
    logic       vld;
    logic [3:0] op;
  } trk_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_issue_sequencer_if.sv
// Instruction-source valid/ready handshake for the issue sequencer.
interface cu_issue_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/cu_instr_fifo.sv
// Synchronous instruction FIFO; wrapping pointers plus a level counter one bit wider.
module cu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cu_issue_sequencer.sv
// Issue sequencer: FIFO-buffered issue to the compute unit with a trailing NOP
// and result tracking. Optional single-step control under SINGLE_STEP_EN.
module cu_issue_sequencer
  import cu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cu_issue_sequencer_if.slave    src,
  input  logic                   ena,
  input  logic                   flush,
`ifdef SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step,
`endif
  output logic [15:0]            cu_instr,
  output logic                   cu_ena,
  output logic                   res_valid,
  output logic [3:0]             res_op,
  output logic                   illegal,
  output logic [7:0]             retired_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);

  seq_state_t  state;
  trk_t        trk;
  logic [15:0] head;
  logic        full, empty;
  logic        accept, legal, push, can_pop, step_ok;

  assign accept       = src.in_valid && src.in_ready;
  assign legal        = is_legal_op(src.in_instr[15:12]);
  assign push         = accept && legal && !flush;
  assign src.in_ready = !full;
  assign can_pop      = ena && !empty && !flush && step_ok;

`ifdef SINGLE_STEP_EN
  logic step_q, step_pulse;

  // Permit lands the cycle after the rising edge so each edge pops exactly once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_q     <= step;
      step_pulse <= step && !step_q;
    end
  end

  assign step_ok = !step_mode || step_pulse;
`else
  assign step_ok = 1'b1;
`endif

  cu_instr_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (can_pop),
    .flush (flush),
    .wdata (src.in_instr),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // State names what cu_instr carries this cycle; DRAIN is the trailing NOP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cu_instr <= NOP_WORD;
      cu_ena   <= 1'b0;
    end else if (can_pop) begin
      state    <= RUN;
      cu_instr <= head;
      cu_ena   <= 1'b1;
    end else if (state == RUN) begin
      state    <= DRAIN;
      cu_instr <= NOP_WORD;
      cu_ena   <= 1'b1;
    end else begin
      state    <= IDLE;
      cu_ena   <= 1'b0;
    end
  end

  // Tracking only advances while the unit is enabled, mirroring its pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk         <= '0;
      res_valid   <= 1'b0;
      res_op      <= 4'h0;
      retired_cnt <= 8'h00;
      illegal     <= 1'b0;
    end else begin
      illegal   <= accept && !legal;
      res_valid <= cu_ena && trk.vld;
      if (cu_ena) begin
        trk <= '{vld: (state == RUN), op: cu_instr[15:12]};
        if (trk.vld) begin
          res_op      <= trk.op;
          retired_cnt <= retired_cnt + 8'd1;
        end
      end
    end
  end

  assign busy = (state != IDLE) || !empty || trk.vld || res_valid;

endmodule

// File: tb/tb_cu_issue_sequencer.sv
// Scoreboard bench for cu_issue_sequencer; step tests run when SINGLE_STEP_EN is defined.
module tb_cu_issue_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, flush;
  logic [15:0] cu_instr;
  logic        cu_ena, res_valid, illegal, busy;
  logic [3:0]  res_op;
  logic [7:0]  retired_cnt;
  logic [2:0]  fifo_level;
`ifdef SINGLE_STEP_EN
  logic        step_mode, step;
`endif

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  cu_issue_sequencer_if src();

  cu_issue_sequencer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src         (src),
    .ena         (ena),
    .flush       (flush),
`ifdef SINGLE_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .cu_instr    (cu_instr),
    .cu_ena      (cu_ena),
    .res_valid   (res_valid),
    .res_op      (res_op),
    .illegal     (illegal),
    .retired_cnt (retired_cnt),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until the handshake completes.
  task automatic push(input logic [15:0] w);
    int n = 0;
    src.in_valid = 1'b1;
    src.in_instr = w;
    while (!src.in_ready && n < 100) begin
      next();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: in_ready stayed 0 for word 0x%0h", w);
    end
    next();
    src.in_valid = 1'b0;
  endtask

  // Monitor: every presented result must match the next expected opcode.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL res_unexpected: got op 0x%0h with nothing expected", res_op);
      end else begin
        chk("res_op", res_op, exp_q.pop_front());
      end
    end
  end

  logic [15:0] burst [4] = '{16'h9105, 16'h9203, 16'hA312, 16'hB412};

  initial begin
    rst_n = 1'b0; ena = 1'b1; flush = 1'b0;
    src.in_valid = 1'b0; src.in_instr = 16'h0;
`ifdef SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    repeat (3) next();
    rst_n = 1'b1;
    chk("rst_in_ready", src.in_ready, 1);
    chk("rst_cu_instr", cu_instr, 16'h0000);
    chk("rst_cu_ena", cu_ena, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired_cnt, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    next();

    // Single LOAD: presented at t+2, DRAIN t+3, result t+4, idle t+5.
    exp_q.push_back(4'h9);
    push(16'h9305);
    chk("t1_level", fifo_level, 1);
    chk("t1_no_ena_yet", cu_ena, 0);
    next();
    chk("t1_run_instr", cu_instr, 16'h9305);
    chk("t1_run_ena", cu_ena, 1);
    next();
    chk("t1_drain_instr", cu_instr, 16'h0000);
    chk("t1_drain_ena", cu_ena, 1);
    next();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_retired", retired_cnt, 1);
    next();
    chk("t1_busy", busy, 0);
    chk("t1_res_clear", res_valid, 0);
    chk("t1_ena_off", cu_ena, 0);

    // Burst with ena low fills the FIFO, then drains back to back.
    ena = 1'b0;
    for (int i = 0; i < 4; i++) push(burst[i]);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_low", src.in_ready, 0);
    src.in_valid = 1'b1; src.in_instr = 16'hA111;
    next();
    src.in_valid = 1'b0;
    chk("t2_level_held", fifo_level, 4);
    exp_q.push_back(4'h9); exp_q.push_back(4'h9);
    exp_q.push_back(4'hA); exp_q.push_back(4'hB);
    ena = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next();
      chk("t2_run_instr", cu_instr, burst[k]);
      chk("t2_run_ena", cu_ena, 1);
    end
    next();
    chk("t2_drain_instr", cu_instr, 16'h0000);
    chk("t2_drain_ena", cu_ena, 1);
    next();
    next();
    chk("t2_retired", retired_cnt, 5);
    chk("t2_busy", busy, 0);

    // Illegal opcode: handshake completes, nothing queued or issued.
    push(16'h5123);
    chk("t3_illegal", illegal, 1);
    chk("t3_level", fifo_level, 0);
    chk("t3_no_ena", cu_ena, 0);
    next();
    chk("t3_illegal_pulse", illegal, 0);
    chk("t3_no_ena2", cu_ena, 0);

    // Flush with one issued and three queued; a concurrent push is dropped.
    ena = 1'b0;
    push(16'hA111); push(16'hB222); push(16'hC333); push(16'hD444);
    exp_q.push_back(4'hA);
    ena = 1'b1;
    next();
    chk("t4_issued", cu_instr, 16'hA111);
    chk("t4_level3", fifo_level, 3);
    flush = 1'b1; src.in_valid = 1'b1; src.in_instr = 16'h9777;
    next();
    flush = 1'b0; src.in_valid = 1'b0;
    chk("t4_flushed", fifo_level, 0);
    chk("t4_drain_instr", cu_instr, 16'h0000);
    chk("t4_drain_ena", cu_ena, 1);
    next();
    chk("t4_idle", cu_ena, 0);
    chk("t4_res", res_valid, 1);
    next();
    chk("t4_busy", busy, 0);
    chk("t4_retired", retired_cnt, 6);

    // Reset while an instruction is in flight loses its result.
    push(16'h9111);
    next();
    chk("t5_inflight", cu_instr, 16'h9111);
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
    chk("t5_cnt", retired_cnt, 0);
    chk("t5_ena", cu_ena, 0);
    chk("t5_level", fifo_level, 0);
    repeat (4) next();
    chk("t5_busy", busy, 0);

    // 255 NOP retirements, then one more wraps the counter.
    for (int i = 0; i < 255; i++) begin
      exp_q.push_back(4'h0);
      push(16'h0000);
    end
    repeat (8) next();
    chk("t6_cnt255", retired_cnt, 255);
    exp_q.push_back(4'h9);
    push(16'h9ABC);
    repeat (6) next();
    chk("t6_wrap", retired_cnt, 0);
    chk("t6_busy", busy, 0);

`ifdef SINGLE_STEP_EN
    // Each rising edge of step issues exactly one word.
    step_mode = 1'b1;
    exp_q.push_back(4'hC); exp_q.push_back(4'hE);
    push(16'hC0F1); push(16'hE020);
    repeat (3) next();
    chk("st_blocked", cu_ena, 0);
    chk("st_level2", fifo_level, 2);
    step = 1'b1;
    next();
    next();
    chk("st_run1", cu_instr, 16'hC0F1);
    chk("st_run1_ena", cu_ena, 1);
    next();
    chk("st_drain1", cu_instr, 16'h0000);
    chk("st_drain1_ena", cu_ena, 1);
    repeat (3) next();
    chk("st_hold_idle", cu_ena, 0);
    chk("st_level1", fifo_level, 1);
    step = 1'b0;
    next();
    step = 1'b1;
    next();
    next();
    chk("st_run2", cu_instr, 16'hE020);
    repeat (4) next();
    chk("st_level0", fifo_level, 0);
    chk("st_idle", cu_ena, 0);
    step = 1'b0; step_mode = 1'b0;
`endif

    repeat (3) next();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
